fft_bitrev_loader: RTL and testbench

Input reorder buffer in front of the first radix-2 DIT butterfly stage. Accepts one N-point frame of complex Q16.16 samples in natural order over a valid/ready stream, stores it, then emits butterfly operand pairs (x, y) in bit-reversed order so stage 1 can compute directly. One frame is held at a time: fill, then drain, then refill.

---
 rtl/fft_bitrev_loader.sv | 128 ++++++++++++
 tb/tb_fft_bitrev_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader
//   Reorder buffer ahead of radix-2 DIT stage 1. Captures one N-point frame of
//   complex samples in natural order, then emits stage-1 butterfly operand
//   pairs (x = sample[bitrev(2k)], y = sample[bitrev(2k+1)]) for k = 0..N/2-1.
//   Fill and drain alternate; only one frame is resident at a time.
// Ports
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      sample stream in (in_re, in_im), natural order
//   out_valid/out_ready    operand pair stream out (xr, xi, yr, yi)
//   out_last               marks the final pair of a frame
module fft_bitrev_loader #(
  parameter int N_LOG2 = 3,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] xr,
  output logic [DW-1:0] xi,
  output logic [DW-1:0] yr,
  output logic [DW-1:0] yi,
  output logic          out_last
);
  localparam int N  = 1 << N_LOG2;
  // Pair counter width; N_LOG2=1 still needs a 1-bit counter that stays 0.
  localparam int KW = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  typedef enum logic {FILL, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [N_LOG2-1:0]   wr_cnt_q, wr_cnt_d;
  logic [KW-1:0]       k_q, k_d;
  sample_t             mem_q [N];

  logic                in_fire, out_fire, k_last;
  logic [N_LOG2-1:0]   idx_x, idx_y, rd_x, rd_y;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] i);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int b = 0; b < N_LOG2; b++) r[b] = i[N_LOG2-1-b];
    return r;
  endfunction

  // Natural-order pair indices 2k and 2k+1, then mapped through bitrev.
  generate
    if (N_LOG2 > 1) begin : g_idx
      assign idx_x = {k_q, 1'b0};
    end else begin : g_idx1
      assign idx_x = '0;
    end
  endgenerate
  assign idx_y = idx_x | N_LOG2'(1);
  assign rd_x  = bitrev(idx_x);
  assign rd_y  = bitrev(idx_y);

  // Handshake flags are pure state decodes so neither ready nor valid
  // depends combinationally on the opposite side of the stream.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_ready && in_valid;
  assign out_fire  = out_valid && out_ready;
  assign k_last    = (k_q == KW'(N/2 - 1));

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    k_d      = k_q;
    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          if (wr_cnt_q == N_LOG2'(N - 1)) begin
            wr_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + N_LOG2'(1);
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (k_last) begin
            k_d     = '0;
            state_d = FILL;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      k_q      <= k_d;
    end
  end

  // Sample storage is deliberately left unreset; outputs are gated instead.
  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wr_cnt_q] <= '{re: in_re, im: in_im};
  end

  // Data forced to zero outside DRAIN so reset and fill show clean outputs.
  assign xr       = out_valid ? mem_q[rd_x].re : '0;
  assign xi       = out_valid ? mem_q[rd_x].im : '0;
  assign yr       = out_valid ? mem_q[rd_y].re : '0;
  assign yi       = out_valid ? mem_q[rd_y].im : '0;
  assign out_last = out_valid && k_last;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Bench for fft_bitrev_loader (N=8, DW=32). Expected pairs are queued when a
// frame has been fed and popped as the DUT hands pairs downstream.
module tb_fft_bitrev_loader;
  typedef logic [31:0] frame_t [8];
  typedef struct {
    logic [31:0] xr, xi, yr, yi;
    logic        last;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_re = '0, in_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] xr, xi, yr, yi;
  logic        out_last;

  int    n_cmp = 0;
  int    n_err = 0;
  pair_t exp_q[$];
  int    ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_bitrev_loader #(.N_LOG2(3), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic frame_t ramp(input logic [31:0] base);
    frame_t f;
    for (int i = 0; i < 8; i++) f[i] = base + 32'(i);
    return f;
  endfunction

  // Drive one frame; bubbles inserts an idle cycle between samples.
  task automatic feed_frame(input frame_t re, input frame_t im, input bit bubbles);
    bit ok;
    int guard;
    pair_t p;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bubbles && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_re = re[i]; in_im = im[i];
      ok = 1'b0; guard = 0;
      while (!ok && guard < 50) begin
        @(negedge clk);
        ok = in_ready;
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL fill_out_valid sample %0d: got %b want 0", i, out_valid);
        end
        @(posedge clk); #1;
        guard++;
      end
      if (!ok) begin
        n_err++;
        $display("FAIL fill_timeout sample %0d: in_ready got 0 want 1", i);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL drain_latency: {in_ready,out_valid} got %b want 01", {in_ready, out_valid});
    end
    for (int k = 0; k < 4; k++) begin
      p.xr = re[ord[2*k]];   p.xi = im[ord[2*k]];
      p.yr = re[ord[2*k+1]]; p.yi = im[ord[2*k+1]];
      p.last = (k == 3);
      exp_q.push_back(p);
    end
  endtask

  // Drain queued pairs; optionally stall one pair and/or present junk input.
  task automatic drain_frame(input int stall_pair, input int stall_cycles, input bit junk);
    int    popped = 0, stalled = 0, guard = 0;
    pair_t e;
    while (exp_q.size() > 0 && guard < 200) begin
      out_ready = !(popped == stall_pair && stalled < stall_cycles);
      if (junk) begin
        in_valid = 1'b1; in_re = 32'hDEAD; in_im = 32'hDEAD;
      end
      @(negedge clk);
      e = exp_q[0];
      n_cmp++;
      if (out_valid !== 1'b1 || {xr, xi, yr, yi, out_last} !== {e.xr, e.xi, e.yr, e.yi, e.last}) begin
        n_err++;
        $display("FAIL pair %0d: got v=%b x=(%h,%h) y=(%h,%h) last=%b want v=1 x=(%h,%h) y=(%h,%h) last=%b",
                 popped, out_valid, xr, xi, yr, yi, out_last, e.xr, e.xi, e.yr, e.yi, e.last);
      end
      if (junk) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL drain_in_ready: got %b want 0", in_ready);
        end
      end
      @(posedge clk); #1;
      guard++;
      if (out_ready) begin
        void'(exp_q.pop_front());
        popped++;
      end else begin
        stalled++;
      end
    end
    if (junk) in_valid = 1'b0;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d pairs left want 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL refill_ready: {in_ready,out_valid} got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({in_ready, out_valid, out_last, xr, xi, yr, yi} !== {3'b100, 128'h0}) begin
      n_err++;
      $display("FAIL %s: rdy=%b vld=%b last=%b x=(%h,%h) y=(%h,%h) want rdy=1 vld=0 last=0 data 0",
               tag, in_ready, out_valid, out_last, xr, xi, yr, yi);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Get into DRAIN, then assert reset between edges.
    feed_frame(ramp(32'h40), ramp(32'h50), 1'b0);
    exp_q.delete();
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ordering();
    feed_frame(ramp(32'd0), ramp(32'd100), 1'b0);
    drain_frame(-1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    feed_frame(ramp(32'd0), ramp(32'd100), 1'b0);
    drain_frame(1, 3, 1'b0);
  endtask

  task automatic test_bubbles_ignored();
    feed_frame(ramp(32'd0), ramp(32'd100), 1'b1);
    drain_frame(-1, 0, 1'b1);
    feed_frame(ramp(32'd50), ramp(32'd150), 1'b0);
    drain_frame(-1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_re = 32'h900 + 32'(i); in_im = 32'h990 + 32'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    feed_frame(ramp(32'h10), ramp(32'h110), 1'b0);
    drain_frame(-1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    frame_t re1, im1;
    re1 = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFF0000, 32'h00010000,
            32'hFFFFFFFF, 32'h00000001, 32'h80000001, 32'h7FFF0000};
    im1 = '{32'h7FFFFFFF, 32'h80000000, 32'h0000FFFF, 32'hFFFF0000,
            32'h00000000, 32'hFFFFFFFE, 32'h12345678, 32'hEDCBA987};
    feed_frame(re1, im1, 1'b0);
    drain_frame(-1, 0, 1'b0);
    feed_frame(ramp(32'h200), ramp(32'hFFFFFFF8), 1'b0);
    drain_frame(2, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_backpressure();
    test_bubbles_ignored();
    test_reset_mid_fill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
